// File: rtl/hazard_ctrl_if.sv
// Pipeline-to-sequencer bundle: hazard sources in, stage controls and status out.
interface hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic             id_useRt;
  logic [4:0]       ex_rs;
  logic [4:0]       ex_rt;
  logic             ex_memRead;
  logic [4:0]       ex_wreg;
  logic             mem_regWrite;
  logic [4:0]       mem_wreg;
  logic             wb_regWrite;
  logic [4:0]       wb_wreg;
  logic             redirect;
  logic             mem_busy;
  logic             pc_en;
  logic             ifid_en;
  logic             ifid_flush;
  logic             idex_en;
  logic             idex_bubble;
  logic             exmem_en;
  logic             memwb_bubble;
  logic [1:0]       fwd_a;
  logic [1:0]       fwd_b;
  logic [1:0]       state;
  logic [CNT_W-1:0] stall_cycles;
  logic             err;

  modport master (
    output id_rs, id_rt, id_useRt, ex_rs, ex_rt, ex_memRead, ex_wreg,
           mem_regWrite, mem_wreg, wb_regWrite, wb_wreg, redirect, mem_busy,
    input  pc_en, ifid_en, ifid_flush, idex_en, idex_bubble, exmem_en,
           memwb_bubble, fwd_a, fwd_b, state, stall_cycles, err
  );

  modport slave (
    input  id_rs, id_rt, id_useRt, ex_rs, ex_rt, ex_memRead, ex_wreg,
           mem_regWrite, mem_wreg, wb_regWrite, wb_wreg, redirect, mem_busy,
    output pc_en, ifid_en, ifid_flush, idex_en, idex_bubble, exmem_en,
           memwb_bubble, fwd_a, fwd_b, state, stall_cycles, err
  );
endinterface

// File: rtl/hazard_ctrl.sv
// 5-stage pipeline sequencer: load-use stall, EX redirect flush, memory-wait freeze,
// EX forwarding selects, stall-cycle counter and sticky memory-timeout error.
module hazard_ctrl #(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 16
) (
  input logic         clk,
  input logic         rst,
  hazard_ctrl_if.slave hz
);
  localparam int WCW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

  typedef enum logic [1:0] {RUN = 2'd0, LU = 2'd1, WAIT = 2'd2, ERR = 2'd3} state_t;

  state_t           st, nxt;
  logic [WCW-1:0]   wcnt;
  logic [CNT_W-1:0] stall_cnt;
  logic             err_q;
  logic             load_use, timeout;
  logic             pc_en, ifid_en, ifid_flush, idex_en, idex_bubble, exmem_en, memwb_bubble;
  logic [1:0]       fwd_a, fwd_b;

  assign load_use = hz.ex_memRead && (hz.ex_wreg != 5'd0) &&
                    ((hz.ex_wreg == hz.id_rs) || (hz.id_useRt && (hz.ex_wreg == hz.id_rt)));
  assign timeout  = hz.mem_busy && (wcnt == WCW'(MEM_TIMEOUT - 1));

  always_comb begin
    pc_en        = 1'b1;
    ifid_en      = 1'b1;
    ifid_flush   = 1'b0;
    idex_en      = 1'b1;
    idex_bubble  = 1'b0;
    exmem_en     = 1'b1;
    memwb_bubble = 1'b0;
    nxt          = RUN;
    if (rst || st == ERR) begin
      pc_en    = 1'b0;
      ifid_en  = 1'b0;
      idex_en  = 1'b0;
      exmem_en = 1'b0;
      nxt      = rst ? RUN : ERR;
    end else if (hz.mem_busy) begin
      pc_en        = 1'b0;
      ifid_en      = 1'b0;
      idex_en      = 1'b0;
      exmem_en     = 1'b0;
      memwb_bubble = 1'b1;
      nxt          = timeout ? ERR : WAIT;
    end else if (hz.redirect) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (load_use && st != LU) begin
      // In LU the bubble already separates load and consumer, so never stall twice.
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_bubble = 1'b1;
      nxt         = LU;
    end
  end

  always_comb begin
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if (!rst) begin
      if (hz.mem_regWrite && hz.mem_wreg != 5'd0 && hz.mem_wreg == hz.ex_rs)      fwd_a = 2'b10;
      else if (hz.wb_regWrite && hz.wb_wreg != 5'd0 && hz.wb_wreg == hz.ex_rs)    fwd_a = 2'b01;
      if (hz.mem_regWrite && hz.mem_wreg != 5'd0 && hz.mem_wreg == hz.ex_rt)      fwd_b = 2'b10;
      else if (hz.wb_regWrite && hz.wb_wreg != 5'd0 && hz.wb_wreg == hz.ex_rt)    fwd_b = 2'b01;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st        <= RUN;
      wcnt      <= '0;
      stall_cnt <= '0;
      err_q     <= 1'b0;
    end else begin
      st   <= nxt;
      wcnt <= hz.mem_busy ? wcnt + 1'b1 : '0;
      if (!pc_en && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
      if (nxt == ERR) err_q <= 1'b1;
    end
  end

  assign hz.pc_en        = pc_en;
  assign hz.ifid_en      = ifid_en;
  assign hz.ifid_flush   = ifid_flush;
  assign hz.idex_en      = idex_en;
  assign hz.idex_bubble  = idex_bubble;
  assign hz.exmem_en     = exmem_en;
  assign hz.memwb_bubble = memwb_bubble;
  assign hz.fwd_a        = fwd_a;
  assign hz.fwd_b        = fwd_b;
  assign hz.state        = st;
  assign hz.stall_cycles = stall_cnt;
  assign hz.err          = err_q;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Randomized bench for hazard_ctrl against a rule-level reference model.
module tb_hazard_ctrl;
  localparam int MT = 4;
  localparam int CW = 6;
  localparam int SAT = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   nvec = 0;
  int   nerr = 0;

  hazard_ctrl_if #(.CNT_W(CW)) hz ();
  hazard_ctrl #(.MEM_TIMEOUT(MT), .CNT_W(CW)) dut (.clk(clk), .rst(rst), .hz(hz));

  always #5 clk = ~clk;

  // reference model: state number, consecutive busy cycles seen, stalls, error flag
  int m_st, m_run, m_stall;
  bit m_err;
  bit e_pc, e_ifid, e_flush, e_idex, e_bub, e_exmem, e_mwb;
  int e_fa, e_fb, e_nst;

  task automatic chk(input string tag, input int got, input int exp);
    nvec++;
    if (got != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int fsel(input logic [4:0] r);
    if (r == 5'd0) return 0;
    if (hz.mem_regWrite && hz.mem_wreg == r) return 2;
    if (hz.wb_regWrite && hz.wb_wreg == r) return 1;
    return 0;
  endfunction

  task automatic eval();
    bit lu;
    lu = hz.ex_memRead && hz.ex_wreg != 0 &&
         (hz.ex_wreg == hz.id_rs || (hz.id_useRt && hz.ex_wreg == hz.id_rt));
    {e_pc, e_ifid, e_idex, e_exmem} = 4'b1111;
    {e_flush, e_bub, e_mwb} = 3'b000;
    e_nst = 0;
    if (rst) begin
      m_st = 0; m_run = 0; m_stall = 0; m_err = 0;
      {e_pc, e_ifid, e_idex, e_exmem} = 4'b0000;
    end else if (m_st == 3) begin
      {e_pc, e_ifid, e_idex, e_exmem} = 4'b0000;
      e_nst = 3;
    end else if (hz.mem_busy) begin
      {e_pc, e_ifid, e_idex, e_exmem} = 4'b0000;
      e_mwb = 1;
      e_nst = (m_run + 1 >= MT) ? 3 : 2;
    end else if (hz.redirect) begin
      e_flush = 1; e_bub = 1;
    end else if (lu && m_st != 1) begin
      e_pc = 0; e_ifid = 0; e_bub = 1;
      e_nst = 1;
    end
    e_fa = rst ? 0 : fsel(hz.ex_rs);
    e_fb = rst ? 0 : fsel(hz.ex_rt);
  endtask

  // called just after a negedge with inputs applied; returns at the next negedge
  task automatic step();
    #1;
    eval();
    chk("pc_en", hz.pc_en, e_pc);
    chk("ifid_en", hz.ifid_en, e_ifid);
    chk("ifid_flush", hz.ifid_flush, e_flush);
    chk("idex_en", hz.idex_en, e_idex);
    chk("idex_bubble", hz.idex_bubble, e_bub);
    chk("exmem_en", hz.exmem_en, e_exmem);
    chk("memwb_bubble", hz.memwb_bubble, e_mwb);
    chk("fwd_a", hz.fwd_a, e_fa);
    chk("fwd_b", hz.fwd_b, e_fb);
    chk("state", hz.state, m_st);
    chk("stall_cycles", hz.stall_cycles, m_stall);
    chk("err", hz.err, m_err);
    @(posedge clk);
    if (!rst) begin
      if (!e_pc) m_stall = (m_stall + 1 > SAT) ? SAT : m_stall + 1;
      m_run = hz.mem_busy ? m_run + 1 : 0;
      if (e_nst == 3) m_err = 1;
      m_st = e_nst;
    end
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    {hz.id_rs, hz.id_rt, hz.ex_rs, hz.ex_rt, hz.ex_wreg, hz.mem_wreg, hz.wb_wreg} = '0;
    {hz.id_useRt, hz.ex_memRead, hz.mem_regWrite, hz.wb_regWrite, hz.redirect, hz.mem_busy} = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    int burst;
    clear_inputs();
    @(negedge clk);
    do_reset();

    // load-use on rs: one stall, then held inputs run through
    hz.ex_memRead = 1; hz.ex_wreg = 5; hz.id_rs = 5;
    step();
    chk("t1_state", hz.state, 1);
    chk("t1_stall", hz.stall_cycles, 1);
    step();
    chk("t1_run", hz.state, 0);

    // rt match without useRt, and $0 destination: no stall
    clear_inputs();
    hz.ex_memRead = 1; hz.ex_wreg = 5; hz.id_rt = 5; hz.id_useRt = 0;
    #1 chk("t2_rt_unused", hz.pc_en, 1);
    step();
    hz.ex_wreg = 0; hz.id_rs = 0; hz.id_useRt = 1; hz.id_rt = 0;
    #1 chk("t2_r0", hz.pc_en, 1);
    step();

    // redirect beats load-use
    hz.ex_wreg = 5; hz.id_rs = 5; hz.redirect = 1;
    #1 chk("t3_flush", hz.ifid_flush, 1);
    step();
    chk("t3_stall", hz.stall_cycles, 1);

    // memory wait with held redirect
    clear_inputs();
    do_reset();
    hz.redirect = 1; hz.mem_busy = 1;
    repeat (3) step();
    chk("t4_wait", hz.state, 2);
    hz.mem_busy = 0;
    #1 chk("t4_redirect", hz.ifid_flush, 1);
    step();
    chk("t4_stall", hz.stall_cycles, 3);

    // timeout, sticky ERR, stall saturation, reset recovery
    clear_inputs();
    do_reset();
    hz.mem_busy = 1;
    repeat (4) step();
    chk("t5_state", hz.state, 3);
    chk("t5_err", hz.err, 1);
    hz.mem_busy = 0;
    repeat (70) step();
    chk("t5_sat", hz.stall_cycles, SAT);
    do_reset();
    chk("t5_clear", hz.err, 0);

    // forwarding priority
    clear_inputs();
    hz.mem_wreg = 7; hz.wb_wreg = 7; hz.ex_rs = 7; hz.mem_regWrite = 1; hz.wb_regWrite = 1;
    #1 chk("t6_mem", hz.fwd_a, 2);
    hz.mem_regWrite = 0;
    #1 chk("t6_wb", hz.fwd_a, 1);
    hz.ex_rs = 0;
    #1 chk("t6_r0", hz.fwd_a, 0);
    step();

    burst = 0;
    for (int i = 0; i < 2000; i++) begin
      hz.id_rs = 5'($urandom_range(0, 7));
      hz.id_rt = 5'($urandom_range(0, 7));
      hz.ex_rs = 5'($urandom_range(0, 7));
      hz.ex_rt = 5'($urandom_range(0, 7));
      hz.ex_wreg = 5'($urandom_range(0, 7));
      hz.mem_wreg = 5'($urandom_range(0, 7));
      hz.wb_wreg = 5'($urandom_range(0, 7));
      hz.id_useRt = 1'($urandom);
      hz.ex_memRead = 1'($urandom);
      hz.mem_regWrite = 1'($urandom);
      hz.wb_regWrite = 1'($urandom);
      hz.redirect = ($urandom_range(0, 6) == 0);
      if (burst == 0 && $urandom_range(0, 7) == 0) burst = $urandom_range(1, 6);
      hz.mem_busy = (burst > 0);
      if (burst > 0) burst--;
      rst = ($urandom_range(0, 99) == 0) || (m_st == 3 && $urandom_range(0, 7) == 0);
      step();
    end
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
